// File: rtl/prog_clk_divider.sv
// Multi-channel runtime-programmable clock divider.
// Each channel divides clk_50mhz by its active divisor N, producing a square
// wave (floor(N/2) low, ceil(N/2) high) and a one-cycle tick on the first high
// cycle. New divisors land in a per-channel shadow register and are applied at
// the next period boundary, or on the next edge while the channel is disabled.
//
// Ports:
//   clk_50mhz  system clock, rising edge
//   rst        synchronous reset, active-low
//   en         per-channel enable
//   cfg_we     one-cycle divisor write strobe
//   cfg_ch     target channel of the write (values >= NCH are ignored)
//   cfg_div    new divisor; 0 and 1 are stored as 2
//   clk_out    divided clock per channel (registered)
//   tick       one-cycle pulse per period, on the first high cycle (registered)
//   pending    written divisor waiting to be applied (registered)
module prog_clk_divider #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned CW      = 32,
  parameter int unsigned DEF_DIV = 50000,
  parameter int unsigned CHW     = 2
) (
  input  logic           clk_50mhz,
  input  logic           rst,
  input  logic [NCH-1:0] en,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_div,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] pending
);

  localparam logic [CW-1:0] DIV_MIN = CW'(2);
  localparam logic [CW-1:0] DIV_RST = CW'(DEF_DIV);

  // Divisors below 2 cannot form a two-phase period; store them as 2.
  logic [CW-1:0] div_clamped_c;
  assign div_clamped_c = (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CW-1:0] cnt;
    logic [CW-1:0] active;
    logic [CW-1:0] shadow;
    logic          pend_q;
    logic          clk_q;
    logic          tick_q;

    logic          wr_c;
    logic          wrap_c;
    logic [CW-1:0] half_c;

    // Matching against the channel index makes out-of-range cfg_ch a no-op.
    assign wr_c   = cfg_we && (cfg_ch == CHW'(i));
    assign half_c = active >> 1;
    // active is never below 2, so active-1 cannot underflow.
    assign wrap_c = (cnt == (active - CW'(1)));

    // Per-channel counter, phase outputs and divisor shadow/apply.
    always_ff @(posedge clk_50mhz) begin
      if (!rst) begin
        cnt    <= '0;
        active <= DIV_RST;
        shadow <= DIV_RST;
        pend_q <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        // A write takes priority over an apply in the same cycle, so a write
        // landing on a wrap is held for the following boundary.
        if (wr_c) begin
          shadow <= div_clamped_c;
          pend_q <= 1'b1;
        end else if (pend_q && (!en[i] || wrap_c)) begin
          active <= shadow;
          pend_q <= 1'b0;
        end

        if (en[i]) begin
          cnt    <= wrap_c ? '0 : cnt + CW'(1);
          clk_q  <= (cnt >= half_c);
          tick_q <= (cnt == half_c);
        end else begin
          cnt    <= '0;
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
        end
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
    assign pending[i] = pend_q;
  end

endmodule

// File: tb/tb_prog_clk_divider.sv
module tb_prog_clk_divider;

  localparam int unsigned CW  = 32;
  localparam int unsigned DEF = 4;

  logic          clk_50mhz = 1'b0;
  logic          rst;
  logic [3:0]    en;
  logic          cfg_we;
  logic [1:0]    cfg_ch;
  logic [CW-1:0] cfg_div;
  logic [3:0]    clk_out, tick, pending;
  logic [2:0]    clk_out3, tick3, pending3;

  int checks   = 0;
  int failures = 0;

  always #10 clk_50mhz = ~clk_50mhz;

  prog_clk_divider #(.NCH(4), .CW(CW), .DEF_DIV(DEF), .CHW(2)) dut (
    .clk_50mhz(clk_50mhz), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .clk_out(clk_out), .tick(tick), .pending(pending)
  );

  prog_clk_divider #(.NCH(3), .CW(CW), .DEF_DIV(DEF), .CHW(2)) dut3 (
    .clk_50mhz(clk_50mhz), .rst(rst), .en(en[2:0]), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .clk_out(clk_out3), .tick(tick3), .pending(pending3)
  );

  // Reference model: set 0 mirrors the 4-channel instance, set 1 the 3-channel.
  // pos = cycles already spent in the current period.
  longint m_n[2][4], m_sh[2][4], m_pos[2][4];
  bit     m_pend[2][4], m_clk[2][4], m_tick[2][4];

  task automatic model_edge(input bit r, input logic [3:0] e, input bit we,
                            input int ch, input longint dv);
    for (int s = 0; s < 2; s++) begin
      int nch = (s == 0) ? 4 : 3;
      for (int c = 0; c < nch; c++) begin
        bit boundary = 1'b0;
        if (!r) begin
          m_pos[s][c] = 0; m_n[s][c] = DEF; m_sh[s][c] = DEF;
          m_pend[s][c] = 0; m_clk[s][c] = 0; m_tick[s][c] = 0;
        end else begin
          if (e[c]) begin
            // First half of the period is low, the rest (incl. odd cycle) high.
            m_clk[s][c]  = (m_pos[s][c] >= m_n[s][c] / 2);
            m_tick[s][c] = (m_pos[s][c] == m_n[s][c] / 2);
            boundary     = (m_pos[s][c] == m_n[s][c] - 1);
            m_pos[s][c]  = boundary ? 0 : m_pos[s][c] + 1;
          end else begin
            m_pos[s][c] = 0; m_clk[s][c] = 0; m_tick[s][c] = 0;
          end
          if (we && ch == c) begin
            m_sh[s][c]   = (dv < 2) ? 2 : dv;
            m_pend[s][c] = 1;
          end else if (m_pend[s][c] && (!e[c] || boundary)) begin
            m_n[s][c]    = m_sh[s][c];
            m_pend[s][c] = 0;
          end
        end
      end
    end
  endtask

  function automatic logic [11:0] exp4();
    logic [11:0] r;
    for (int c = 0; c < 4; c++) begin
      r[8+c] = m_clk[0][c]; r[4+c] = m_tick[0][c]; r[c] = m_pend[0][c];
    end
    return r;
  endfunction

  function automatic logic [8:0] exp3();
    logic [8:0] r;
    for (int c = 0; c < 3; c++) begin
      r[6+c] = m_clk[1][c]; r[3+c] = m_tick[1][c]; r[c] = m_pend[1][c];
    end
    return r;
  endfunction

  // One clock: sample inputs, advance the model, settle, drop the write strobe.
  task automatic step();
    bit         r  = rst;
    logic [3:0] e  = en;
    bit         we = cfg_we;
    int         ch = int'(cfg_ch);
    longint     dv = longint'(cfg_div);
    @(posedge clk_50mhz);
    model_edge(r, e, we, ch, dv);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 4'hF;
    step(); step();
    checks++;
    if ({clk_out, tick, pending} !== 12'h000) begin
      failures++; $display("FAIL reset4 got=%h exp=000", {clk_out, tick, pending});
    end
    checks++;
    if ({clk_out3, tick3, pending3} !== 9'h000) begin
      failures++; $display("FAIL reset3 got=%h exp=000", {clk_out3, tick3, pending3});
    end
    rst = 1'b1;
  endtask

  task automatic test_default_period();
    logic [3:0] pat_clk  = 4'b1100;
    logic [3:0] pat_tick = 4'b0100;
    for (int k = 0; k < 12; k++) begin
      step();
      checks++;
      if (clk_out !== {4{pat_clk[k%4]}} || tick !== {4{pat_tick[k%4]}} || pending !== 4'h0) begin
        failures++;
        $display("FAIL default_period k=%0d got clk=%b tick=%b pend=%b exp clk=%b tick=%b pend=0000",
                 k, clk_out, tick, pending, {4{pat_clk[k%4]}}, {4{pat_tick[k%4]}});
      end
    end
  endtask

  task automatic test_write_mid_period();
    logic [4:0] pat = 5'b11100;
    bit dropped = 1'b0;
    step();
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = CW'(5);
    step();
    checks++;
    if (pending[1] !== 1'b1) begin
      failures++; $display("FAIL write_mid_pending got=%b exp=1", pending[1]);
    end
    for (int k = 0; k < 10 && !dropped; k++) begin
      step();
      checks++;
      if ({clk_out, tick, pending} !== exp4()) begin
        failures++; $display("FAIL write_mid_model got=%h exp=%h", {clk_out, tick, pending}, exp4());
      end
      dropped = (pending[1] === 1'b0);
    end
    checks++;
    if (!dropped) begin
      failures++; $display("FAIL write_mid_timeout got=pending exp=applied");
    end
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (clk_out[1] !== pat[k%5] || {clk_out, tick, pending} !== exp4()) begin
        failures++;
        $display("FAIL write_mid_n5 k=%0d got clk1=%b all=%h exp clk1=%b all=%h",
                 k, clk_out[1], {clk_out, tick, pending}, pat[k%5], exp4());
      end
    end
  endtask

  task automatic test_clamp();
    for (int w = 0; w < 2; w++) begin
      bit dropped = 1'b0;
      cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = CW'(w);
      step();
      for (int k = 0; k < 10 && !dropped; k++) begin
        step();
        dropped = (pending[2] === 1'b0);
      end
      checks++;
      if (!dropped) begin
        failures++; $display("FAIL clamp_timeout div=%0d got=pending exp=applied", w);
      end
      for (int k = 0; k < 4; k++) begin
        step();
        checks++;
        if (clk_out[2] !== k[0] || {clk_out, tick, pending} !== exp4()) begin
          failures++;
          $display("FAIL clamp div=%0d k=%0d got clk2=%b all=%h exp clk2=%b all=%h",
                   w, k, clk_out[2], {clk_out, tick, pending}, k[0], exp4());
        end
      end
    end
  endtask

  task automatic test_last_write_wins();
    logic [5:0] pat = 6'b111000;
    bit dropped = 1'b0;
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = CW'(8);
    step();
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = CW'(6);
    step();
    for (int k = 0; k < 12 && !dropped; k++) begin
      step();
      dropped = (pending[0] === 1'b0);
    end
    checks++;
    if (!dropped) begin
      failures++; $display("FAIL last_write_timeout got=pending exp=applied");
    end
    for (int k = 0; k < 12; k++) begin
      step();
      checks++;
      if (clk_out[0] !== pat[k%6] || {clk_out, tick, pending} !== exp4()) begin
        failures++;
        $display("FAIL last_write_n6 k=%0d got clk0=%b all=%h exp clk0=%b all=%h",
                 k, clk_out[0], {clk_out, tick, pending}, pat[k%6], exp4());
      end
    end
  endtask

  task automatic test_write_on_wrap();
    int waited = 0;
    int held   = 0;
    bit found  = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      if (m_pos[0][0] == m_n[0][0] - 1) found = 1'b1;
      else step();
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL wrap_search_timeout got=none exp=wrap");
    end
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = CW'(3);
    step();
    checks++;
    if (pending[0] !== 1'b1) begin
      failures++; $display("FAIL write_on_wrap_pending got=%b exp=1", pending[0]);
    end
    while (pending[0] === 1'b1 && waited < 20) begin
      step();
      waited++;
      held++;
    end
    checks++;
    if (held !== 6) begin
      failures++; $display("FAIL write_on_wrap_delay got=%0d exp=6", held);
    end
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if ({clk_out, tick, pending} !== exp4()) begin
        failures++; $display("FAIL write_on_wrap_model got=%h exp=%h", {clk_out, tick, pending}, exp4());
      end
    end
  endtask

  task automatic test_disable();
    bit found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      step();
      found = (clk_out[3] === 1'b1);
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL disable_search_timeout got=low exp=high");
    end
    en[3] = 1'b0;
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = CW'(10);
    step();
    checks++;
    if (clk_out[3] !== 1'b0 || pending[3] !== 1'b1) begin
      failures++; $display("FAIL disable_first got clk3=%b pend3=%b exp clk3=0 pend3=1", clk_out[3], pending[3]);
    end
    step();
    checks++;
    if (pending[3] !== 1'b0) begin
      failures++; $display("FAIL disable_apply got pend3=%b exp=0", pending[3]);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (clk_out[3] !== 1'b0 || tick[3] !== 1'b0) begin
        failures++; $display("FAIL disable_idle k=%0d got clk3=%b tick3=%b exp 0 0", k, clk_out[3], tick[3]);
      end
    end
    en[3] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      checks++;
      if (clk_out[3] !== ((k % 10) >= 5) || tick[3] !== ((k % 10) == 5)) begin
        failures++;
        $display("FAIL reenable_n10 k=%0d got clk3=%b tick3=%b exp clk3=%b tick3=%b",
                 k, clk_out[3], tick[3], (k % 10) >= 5, (k % 10) == 5);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] pat = 4'b1100;
    step();
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = CW'(7);
    step();
    checks++;
    if (pending[1] !== 1'b1) begin
      failures++; $display("FAIL reset_mid_pending got=%b exp=1", pending[1]);
    end
    rst = 1'b0;
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = CW'(9);
    step();
    checks++;
    if ({clk_out, tick, pending} !== 12'h000 || {clk_out3, tick3, pending3} !== 9'h000) begin
      failures++;
      $display("FAIL reset_mid_outputs got4=%h got3=%h exp=0", {clk_out, tick, pending}, {clk_out3, tick3, pending3});
    end
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (clk_out !== {4{pat[k%4]}} || pending !== 4'h0) begin
        failures++;
        $display("FAIL reset_mid_default k=%0d got clk=%b pend=%b exp clk=%b pend=0000",
                 k, clk_out, pending, {4{pat[k%4]}});
      end
    end
  endtask

  task automatic test_bad_channel();
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = CW'(3);
    step();
    checks++;
    if (pending3 !== 3'b000) begin
      failures++; $display("FAIL bad_channel_pending got=%b exp=000", pending3);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if ({clk_out3, tick3, pending3} !== exp3() || {clk_out, tick, pending} !== exp4()) begin
        failures++;
        $display("FAIL bad_channel_model k=%0d got3=%h exp3=%h got4=%h exp4=%h",
                 k, {clk_out3, tick3, pending3}, exp3(), {clk_out, tick, pending}, exp4());
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      rst = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 29) == 0) en = en ^ 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        cfg_we  = 1'b1;
        cfg_ch  = 2'($urandom_range(0, 3));
        cfg_div = CW'($urandom_range(0, 12));
      end
      step();
      checks++;
      if ({clk_out, tick, pending} !== exp4() || {clk_out3, tick3, pending3} !== exp3()) begin
        failures++;
        $display("FAIL random k=%0d got4=%h exp4=%h got3=%h exp3=%h",
                 k, {clk_out, tick, pending}, exp4(), {clk_out3, tick3, pending3}, exp3());
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; en = 4'h0; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_div = '0;
    test_reset();
    test_default_period();
    test_write_mid_period();
    test_clamp();
    test_last_write_wins();
    test_write_on_wrap();
    test_disable();
    test_reset_mid();
    test_bad_channel();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_clk_divider.md
Name: prog_clk_divider

Overview:
- Multi-channel, runtime-programmable clock divider. Successor to the fixed four-output divider.
- Each channel derives a divided square wave and a one-cycle tick from the 50 MHz system clock.
- Divisors are per-channel, loaded through a simple write port and applied glitch-free at period boundaries.
- Sits at the top of the experiment designs and feeds scan, debounce and counter timebases.

Parameters:
- NCH, 4, number of divider channels (1..16).
- CW, 32, counter and divisor width in bits.
- DEF_DIV, 50000, reset divisor loaded into every channel. Must be >= 2.
- CHW, 2, width of cfg_ch. Must satisfy 2^CHW >= NCH.

Ports:
- clk_50mhz  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-low. Sampled on the rising edge of clk_50mhz.
- en  in  NCH  per-channel enable; bit i controls channel i.
- cfg_we  in  1  one-cycle divisor write strobe.
- cfg_ch  in  CHW  target channel of the write.
- cfg_div  in  CW  new divisor N for the target channel.
- clk_out  out  NCH  divided clock per channel, registered.
- tick  out  NCH  one-cycle pulse per channel period, registered.
- pending  out  NCH  bit i is 1 while a written divisor waits to be applied on channel i.

Behaviour:
- Reset (rst=0 on a clock edge) sets every channel as follows:
  - cnt=0
  - active divisor = DEF_DIV
  - shadow divisor = DEF_DIV
  - clk_out=0, tick=0, pending=0
- Reset overrides all other inputs, including a write in the same cycle. Reset mid-period discards the partial period and any pending value.
- Divisor clamp: a written value below 2 (0 or 1) is stored as 2.
- Period of channel i with active divisor N is exactly N clk_50mhz cycles:
  - low phase = floor(N/2) cycles, then high phase = ceil(N/2) cycles;
  - for odd N the extra cycle is in the high phase;
  - cnt runs 0..N-1;
  - clk_out=1 when cnt >= floor(N/2), registered so that clk_out follows cnt with 1-cycle latency.
- The first period after reset release, or after enable, starts with the low phase. Example: N=4 gives 2 low, 2 high. N=10 at 50 MHz gives 5 MHz.
- tick[i] is 1 for exactly one cycle, coincident with the first high cycle of clk_out[i]. It occurs once per period.
- Wrap: when cnt==N-1, the next cnt is 0. This boundary is the only point where the active divisor may change while the channel is enabled.
- Write (cfg_we=1, cfg_ch<NCH):
  - shadow[cfg_ch] <= clamp(cfg_div), and pending[cfg_ch] <= 1 on the next edge;
  - a second write before the apply overwrites the shadow; last write wins;
  - cfg_ch >= NCH: the write is ignored, with no state change.
- Apply:
  - On the wrap edge of a pending channel: active <= shadow, pending <= 0, and the next period uses the new N.
  - A write in the same cycle as a wrap on the same channel is not applied at that wrap. It stays pending for the following wrap, and any earlier pending value is superseded.
- Disabled channel (en[i]=0):
  - cnt held at 0, clk_out=0, tick=0;
  - a pending divisor is applied on the next edge; pending clears 1 cycle after the write.
- Re-enable: the first period starts at cnt=0, low phase, with the active N.
- Deasserting en mid-period forces clk_out low on the next edge. This is the only permitted truncated pulse.
- Channels are fully independent. Simultaneous wraps or ticks on several channels are all honoured.
- Counter arithmetic is unsigned CW-bit. N up to 2^CW-1 is legal, with no overflow because cnt never exceeds N-1.

Test Plan:
- Reset, en=all 1, NCH=4, DEF_DIV=4 -> every clk_out shows 2 low, 2 high repeating; tick pulses every 4 cycles on the first high cycle; pending=0.
- Write ch1 N=5 mid-period -> pending[1]=1 until ch1 wrap; the current 4-cycle period completes; the next periods are 2 low, 3 high; pending[1] drops on the wrap edge.
- Write ch2 N=0 and, on a later write, N=1 -> each behaves as N=2, giving alternating 1 low, 1 high.
- Write ch0 N=8 then N=6 before the wrap -> only N=6 is applied (3 low, 3 high). Separately, a write landing on the wrap cycle -> applied one period later.
- en[3]=0 for 7 cycles mid-high-phase, with write N=10 while disabled -> clk_out[3]=0 on the next edge; pending clears after 1 cycle; after re-enable, 5 low, 5 high; no ticks while disabled.
- rst=0 for 1 cycle mid-period with ch1 pending -> all outputs 0; divisor back to DEF_DIV; pending cleared. A write with cfg_ch=3 when NCH=3 -> no effect.
